// File: rtl/axil_slv_pkg.sv
// Shared response codes, FSM state types and the status-word index for the AXI-Lite register slave.
// AXIL_SLV_ERR_EN selects SLVERR instead of OKAY for out-of-range accesses.
package axil_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         STATUS_IDX  = 0;

`ifdef AXIL_SLV_ERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axil_slv_regfile.sv
// Register storage: per-byte strobe merge, registered write pulses, asynchronous read mux.
// Word STATUS_IDX is never stored, so its regs_out slice stays zero.
module axil_slv_regfile
    import axil_slv_pkg::*;
#(
    parameter int NUM_REGS = 16,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    logic [NUM_REGS-1:0][31:0] regs;

    // wr_pulse lands in the same cycle the new value shows on regs_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (we && wr_idx != IDX_W'(STATUS_IDX)) begin
                wr_pulse[wr_idx] <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data  = regs[rd_idx];
    assign regs_out = regs;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: independent write (AW/W in any order) and read FSMs over axil_slv_regfile.
// Out-of-range response code follows AXIL_SLV_ERR_EN (see axil_slv_pkg).
module axil_reg_slave
    import axil_slv_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 16
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    input  logic [31:0]                 status_in,
    output logic [NUM_REGS*32-1:0]      regs_out,
    output logic [NUM_REGS-1:0]         wr_pulse
);

    localparam int                  IDX_W = $clog2(NUM_REGS);
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(NUM_REGS * 4);

    if (AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axil_reg_slave: AXI_DATA_WIDTH must be 32");
    end

    wr_state_t                  wr_state, wr_next;
    rd_state_t                  rd_state, rd_next;
    logic                       aw_held, w_held;
    logic [AXI_ADDR_WIDTH-1:0]  awaddr_q;
    logic [31:0]                wdata_q;
    logic [3:0]                 wstrb_q;
    logic [1:0]                 bresp_q, rresp_q;
    logic [31:0]                rdata_q;

    logic                       aw_hs, w_hs, ar_hs, commit, wr_oor, rd_oor;
    logic [AXI_ADDR_WIDTH-1:0]  awaddr_eff;
    logic [31:0]                wdata_eff, reg_rd_data;
    logic [3:0]                 wstrb_eff;

    // A channel accepted earlier is replayed from its holding register
    assign awaddr_eff = aw_held ? awaddr_q : s_axi_awaddr;
    assign wdata_eff  = w_held  ? wdata_q  : s_axi_wdata;
    assign wstrb_eff  = w_held  ? wstrb_q  : s_axi_wstrb;
    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign ar_hs      = s_axi_arvalid && s_axi_arready;
    assign wr_oor     = awaddr_eff >= SPAN;
    assign rd_oor     = s_axi_araddr >= SPAN;

    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        commit        = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                s_axi_awready = !aw_held;
                s_axi_wready  = !w_held;
                commit        = (aw_held || aw_hs) && (w_held || w_hs);
                if (commit) wr_next = WR_RESP;
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) rd_next = RD_DATA;
            end
            RD_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state <= WR_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_oor ? OOR_RESP : RESP_OKAY;
            end
        end
    end

    // Read data is captured at the AR handshake, before any same-cycle write lands
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                if (rd_oor)                                         rdata_q <= '0;
                else if (s_axi_araddr[2 +: IDX_W] == IDX_W'(STATUS_IDX)) rdata_q <= status_in;
                else                                                rdata_q <= reg_rd_data;
                rresp_q <= rd_oor ? OOR_RESP : RESP_OKAY;
            end
        end
    end

    assign s_axi_bresp = bresp_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;

    axil_slv_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk      (s_axi_aclk),
        .rst_n    (s_axi_aresetn),
        .we       (commit && !wr_oor),
        .wr_idx   (awaddr_eff[2 +: IDX_W]),
        .wr_data  (wdata_eff),
        .wr_strb  (wstrb_eff),
        .rd_idx   (s_axi_araddr[2 +: IDX_W]),
        .rd_data  (reg_rd_data),
        .regs_out (regs_out),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized bench for axil_reg_slave against an array-based register model.
// Expected out-of-range response follows AXIL_SLV_ERR_EN.
module tb_axil_reg_slave;

    localparam int NR = 16;

`ifdef AXIL_SLV_ERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   awaddr = '0, wdata = '0, araddr = '0, status = '0;
    logic [3:0]    wstrb = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [NR*32-1:0] regs_out;
    logic [NR-1:0] wr_pulse;

    always #5 clk = ~clk;

    axil_reg_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .status_in(status), .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    int checks = 0, failures = 0;
    logic [31:0] model [NR];
    int pulse_cnt [NR];

    initial for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
    always @(posedge clk) for (int i = 0; i < NR; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NR; i++) chk(tag, regs_out[32*i +: 32], model[i]);
    endtask

    // Entry and exit at posedge+1; DUT outputs sampled on negedge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0;
        int cyc = 0;
        bit inr = addr < NR * 4;
        int idx = int'(addr[5:2]);
        logic [NR-1:0] exp_pulse = '0;
        while (!(aw_done && w_done)) begin
            if (cyc > 60) begin
                awvalid = 0; wvalid = 0;
                chk("wr_hs_timeout", 32'd1, 32'd0);
                return;
            end
            awvalid = !aw_done && cyc >= aw_dly; awaddr = addr;
            wvalid  = !w_done && cyc >= w_dly;   wdata = data; wstrb = strb;
            @(negedge clk);
            if (aw_done) chk("awready_low_after_aw", 32'(awready), 0);
            if (w_done)  chk("wready_low_after_w", 32'(wready), 0);
            if (!w_done || !aw_done) chk("bvalid_early", 32'(bvalid), 0);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done = 1;
            @(posedge clk); #1; cyc++;
        end
        awvalid = 0; wvalid = 0;
        if (inr && idx != 0) begin
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        @(negedge clk);
        chk("bvalid_latency", 32'(bvalid), 1);
        chk("bresp", 32'(bresp), 32'(inr ? 2'b00 : EXP_OOR));
        chk("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
        chk_regs("regs_out");
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bvalid_hold", 32'(bvalid), 1);
            chk("bresp_hold", 32'(bresp), 32'(inr ? 2'b00 : EXP_OOR));
            chk("awready_hold_low", 32'(awready), 0);
            chk("wr_pulse_single", 32'(wr_pulse), 0);
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        @(negedge clk);
        chk("bvalid_drop", 32'(bvalid), 0);
        chk("awready_rearm", 32'(awready), 1);
        chk("wready_rearm", 32'(wready), 1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
        int cyc = 0;
        bit inr = addr < NR * 4;
        int idx = int'(addr[5:2]);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        repeat (ar_dly) begin @(posedge clk); #1; end
        arvalid = 1; araddr = addr;
        forever begin
            @(negedge clk);
            if (arready) break;
            if (++cyc > 20) begin
                arvalid = 0;
                chk("ar_hs_timeout", 32'd1, 32'd0);
                return;
            end
        end
        exp_d = !inr ? 32'h0 : (idx == 0 ? status : model[idx]);
        exp_r = inr ? 2'b00 : EXP_OOR;
        @(posedge clk); #1;
        arvalid = 0;
        @(negedge clk);
        chk("rvalid_latency", 32'(rvalid), 1);
        chk("rdata", rdata, exp_d);
        chk("rresp", 32'(rresp), 32'(exp_r));
        chk("arready_low", 32'(arready), 0);
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rvalid_hold", 32'(rvalid), 1);
            chk("rdata_hold", rdata, exp_d);
            chk("rresp_hold", 32'(rresp), 32'(exp_r));
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        @(negedge clk);
        chk("rvalid_drop", 32'(rvalid), 0);
        chk("arready_rearm", 32'(arready), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int c1;
        logic [31:0] a, r;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(awready), 1);
        chk("rst_wready", 32'(wready), 1);
        chk("rst_arready", 32'(arready), 1);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_bresp", 32'(bresp), 0);
        chk("rst_rresp", 32'(rresp), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_wr_pulse", 32'(wr_pulse), 0);
        chk_regs("rst_regs");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        status = 32'h0000_0900;
        do_read(32'h0, 0, 0);

        c1 = pulse_cnt[1];
        do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_write(32'h4, 32'h1122_3344, 4'h5, 0, 0, 0);
        do_read(32'h4, 0, 0);
        chk("reg1_merge", regs_out[63:32], 32'hDE22_BE44);
        chk("reg1_pulses", 32'(pulse_cnt[1] - c1), 2);

        do_write(32'h8, 32'hA5A5_A5A5, 4'hF, 3, 0, 0);   // W leads AW by 3 cycles
        do_read(32'h8, 0, 0);
        do_write(32'h10, 32'h0BAD_F00D, 4'hF, 0, 2, 0);  // AW leads W

        do_write(32'hC, 32'h1234_5678, 4'hF, 0, 0, 10);
        do_read(32'hC, 0, 10);

        do_write(32'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        status = 32'h5A5A_0001;
        do_read(32'h0, 0, 0);
        chk("word0_zero", regs_out[31:0], 0);

        do_write(32'h40, 32'hCAFE_CAFE, 4'hF, 0, 0, 0);
        do_read(32'h40, 0, 0);

        c1 = pulse_cnt[5];
        do_write(32'h14, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        chk("strb0_pulse", 32'(pulse_cnt[5] - c1), 1);

        // read captured in the commit cycle returns the old value
        fork
            do_write(32'h18, 32'h7777_8888, 4'hF, 0, 0, 0);
            do_read(32'h18, 0, 0);
        join

        for (int n = 0; n < 120; n++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NR * 4 + 12));
            r = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NR * 4 + 12));
            status = $urandom;
            fork
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
                do_read(r, $urandom_range(0, 3), $urandom_range(0, 3));
            join
        end

        // reset mid-write aborts without a response
        awvalid = 1; awaddr = 32'h4;
        @(posedge clk); #1;
        awvalid = 0;
        rst_n = 0;
        #1;
        chk("midrst_awready", 32'(awready), 1);
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clk);
        chk("midrst_bvalid", 32'(bvalid), 0);
        chk_regs("midrst_regs");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        do_write(32'h8, 32'h0000_00FF, 4'h1, 1, 0, 0);
        do_read(32'h8, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
